// File: rtl/fp16_pkg.sv
// Shared definitions for the half-precision adder datapath.
package fp16_pkg;

    localparam int unsigned EXP_W   = 5;
    localparam int unsigned FRAC_W  = 10;
    localparam int unsigned BIAS    = 15;
    localparam int unsigned EXP_MAX = 31;
    localparam int unsigned MAN_W   = FRAC_W + 5;

    // Bit positions inside the raw 15-bit mantissa
    localparam int unsigned CARRY_BIT  = 14;
    localparam int unsigned HIDDEN_BIT = 13;
    localparam int unsigned GUARD_BIT  = 2;
    localparam int unsigned ROUND_BIT  = 1;
    localparam int unsigned STICKY_BIT = 0;

    // Raw, unnormalised sum as produced by the adder stage
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } raw_sum_t;

    typedef enum logic [1:0] {
        KindNorm,
        KindSpecial,
        KindZero
    } s1_kind_e;

    // Normalised value handed from stage 1 to stage 2; man is {hidden, frac, G, R, S}
    typedef struct packed {
        s1_kind_e         kind;
        logic             sign;
        logic             underflow;
        logic [EXP_W:0]   exp;
        logic [MAN_W-2:0] man;
    } s1_reg_t;

endpackage

// File: rtl/fp16_lzc.sv
// Combinational 14-bit leading-zero counter.
module fp16_lzc
    import fp16_pkg::*;
(
    input  logic [HIDDEN_BIT:0] data_i,
    output logic [3:0]          count_o,
    output logic                zero_o
);

    // Scan upward so the highest set bit makes the final assignment
    always_comb begin
        count_o = 4'd14;
        for (int i = 0; i <= int'(HIDDEN_BIT); i++) begin
            if (data_i[i]) begin
                count_o = 4'(int'(HIDDEN_BIT) - i);
            end
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/fp16_norm_round.sv
// Normalise, round-to-nearest-even and pack a raw binary16 sum (two-stage pipeline).
module fp16_norm_round
    import fp16_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MAN_W-1:0]        in_man,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_overflow,
    output logic                    out_underflow,
    output logic                    out_inexact
);

    raw_sum_t raw;
    s1_reg_t  s1_d, s1_q;
    logic     s1_valid_q, s2_valid_q;
    logic     s1_adv, s2_adv;
    logic [3:0] lz;
    logic       lz_zero;
    logic [EXP_W:0] exp_sub;

    logic [EXP_W+FRAC_W:0] res_d, res_q;
    logic ovf_d, ovf_q, unf_d, unf_q, inx_d, inx_q;
    logic [FRAC_W+1:0] rnd_sum;
    logic              round_up;
    logic [EXP_W:0]    exp_fin;

    assign raw = {in_sign, in_exp, in_man};

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    fp16_lzc u_lzc (
        .data_i  (raw.man[HIDDEN_BIT:0]),
        .count_o (lz),
        .zero_o  (lz_zero)
    );

    // Stage 1: classify and normalise; 6-bit exponent catches both wrap directions
    always_comb begin
        s1_d      = '0;
        s1_d.sign = raw.sign;
        exp_sub   = {1'b0, raw.exp} - {2'b00, lz};
        if (raw.exp == EXP_W'(EXP_MAX)) begin
            s1_d.kind = KindSpecial;
            s1_d.man  = raw.man[HIDDEN_BIT:0];
        end else if (!raw.man[CARRY_BIT] && lz_zero) begin
            s1_d.kind = KindZero;
        end else if (raw.man[CARRY_BIT]) begin
            s1_d.kind = KindNorm;
            s1_d.exp  = {1'b0, raw.exp} + 6'd1;
            // R and S both fall below the new guard, so they merge into sticky
            s1_d.man  = {raw.man[CARRY_BIT:GUARD_BIT], |raw.man[ROUND_BIT:STICKY_BIT]};
        end else if (exp_sub[EXP_W] || exp_sub == '0) begin
            s1_d.kind      = KindZero;
            s1_d.underflow = 1'b1;
        end else begin
            s1_d.kind = KindNorm;
            s1_d.exp  = exp_sub;
            s1_d.man  = raw.man[HIDDEN_BIT:0] << lz;
        end
    end

    // Stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            s1_q       <= s1_d;
        end
    end

    // Stage 2: round to nearest-even, detect overflow, pack
    always_comb begin
        res_d    = '0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inx_d    = 1'b0;
        round_up = s1_q.man[GUARD_BIT] &
                   (s1_q.man[ROUND_BIT] | s1_q.man[STICKY_BIT] | s1_q.man[GUARD_BIT+1]);
        rnd_sum  = {1'b0, s1_q.man[HIDDEN_BIT:GUARD_BIT+1]} + {{(FRAC_W+1){1'b0}}, round_up};
        exp_fin  = s1_q.exp + {{EXP_W{1'b0}}, rnd_sum[FRAC_W+1]};
        unique case (s1_q.kind)
            KindSpecial: begin
                res_d = {s1_q.sign, EXP_W'(EXP_MAX), s1_q.man[HIDDEN_BIT-1:GUARD_BIT+1]};
            end
            KindZero: begin
                res_d = {s1_q.sign, {(EXP_W+FRAC_W){1'b0}}};
                unf_d = s1_q.underflow;
            end
            default: begin
                inx_d = |s1_q.man[GUARD_BIT:STICKY_BIT];
                if (exp_fin >= (EXP_W+1)'(EXP_MAX)) begin
                    res_d = {s1_q.sign, EXP_W'(EXP_MAX), {FRAC_W{1'b0}}};
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                end else begin
                    // On carry-out rnd_sum is 0x800, so the low bits are already zero
                    res_d = {s1_q.sign, exp_fin[EXP_W-1:0], rnd_sum[FRAC_W-1:0]};
                end
            end
        endcase
    end

    // Stage 2 / output register; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            inx_q      <= inx_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign out_result    = res_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_inexact   = inx_q;

endmodule
